// File: rtl/fc_pkg.sv
// Shared types and helpers for the parametrised fully-connected layer engine.
package fc_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FINISH} fc_state_t;

  // Widest intermediate the saturate helper accepts; covers DATA_WIDTH up to 63.
  localparam int SAT_W = 128;

  function automatic int acc_width(input int data_w);
    return 2 * data_w;
  endfunction

  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Clamp a sign-extended value into the signed range of an out_w-bit word.
  function automatic logic signed [SAT_W-1:0] saturate(input logic signed [SAT_W-1:0] val,
                                                       input int out_w);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (SAT_W'(1) <<< (out_w - 1)) - SAT_W'(1);
    lo = ~hi;
    if (val > hi)
      return hi;
    else if (val < lo)
      return lo;
    else
      return val;
  endfunction

endpackage

// File: rtl/fc_mac_lane.sv
// One neuron lane: weight RAM, multiply-accumulate, bias add, saturation and optional ReLU.
module fc_mac_lane
  import fc_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int FRAC_BITS = 16,
  parameter int DEPTH     = 84,
  parameter int IDX_W     = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wm_we,
  input  logic [IDX_W-1:0]  wm_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              bm_we,
  input  logic [IDX_W-1:0]  rd_addr_p0,
  input  logic [DATA_W-1:0] elem_p1,
  input  logic              vld_p1,
  input  logic              acc_clr,
  input  logic              fin_en,
  input  logic              relu_mode,
  output logic [DATA_W-1:0] result
);

  localparam int ACC_W = acc_width(DATA_W);

  logic signed [DATA_W-1:0] mem [DEPTH];
  logic signed [DATA_W-1:0] w_p1;
  logic signed [DATA_W-1:0] x_p1;
  logic signed [DATA_W-1:0] bias;
  logic signed [ACC_W-1:0]  prod_p1;
  logic signed [ACC_W-1:0]  acc_p2;
  logic signed [ACC_W:0]    sum_p2;
  logic signed [DATA_W-1:0] res_p2;

  // p0 -> p1: synchronous weight read
  always_ff @(posedge clk) begin
    if (wm_we)
      mem[wm_addr] <= wr_data;
    w_p1 <= mem[rd_addr_p0];
  end

  assign x_p1    = elem_p1;
  assign prod_p1 = (ACC_W'(w_p1) * ACC_W'(x_p1)) >>> FRAC_BITS;

  // p1 -> p2: accumulate, wrapping at ACC_W bits
  always_ff @(posedge clk) begin
    if (acc_clr)
      acc_p2 <= '0;
    else if (vld_p1)
      acc_p2 <= acc_p2 + prod_p1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      bias <= '0;
    else if (bm_we)
      bias <= wr_data;
  end

  // One extra bit so the bias add itself never wraps before clamping.
  assign sum_p2 = (ACC_W+1)'(acc_p2) + (ACC_W+1)'(bias);

  always_comb begin
    res_p2 = DATA_W'(saturate(SAT_W'(sum_p2), DATA_W));
    if (relu_mode && res_p2[DATA_W-1])
      res_p2 = '0;
  end

  // p2 -> output register
  always_ff @(posedge clk) begin
    if (rst)
      result <= '0;
    else if (fin_en)
      result <= res_p2;
  end

endmodule

// File: rtl/fc_layer_gen.sv
// Fully-connected layer engine: control FSM, element counter, host write decode and
// NUM_NEURONS parallel MAC lanes.
module fc_layer_gen
  import fc_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int FRAC_BITS    = 16,
  parameter int IFM_DEPTH    = 84,
  parameter int NUM_NEURONS  = 10,
  parameter int ADDRESS_BITS = 15,
  parameter bit RELU_EN      = 1'b0
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [DATA_WIDTH-1:0]             riscv_data,
  input  logic [ADDRESS_BITS-1:0]           riscv_address,
  input  logic [NUM_NEURONS-1:0]            wm_enable_write,
  input  logic                              bm_enable_write,
  input  logic                              relu_mode_wr,
  input  logic                              start_from_previous,
  input  logic [IFM_DEPTH*DATA_WIDTH-1:0]   ifm_data,
  output logic                              end_to_previous,
  output logic [NUM_NEURONS*DATA_WIDTH-1:0] fc_out,
  output logic                              output_valid,
  output logic                              output_ready,
  output logic                              busy
);

  localparam int IDX_W = idx_width(IFM_DEPTH);

  fc_state_t        state;
  fc_state_t        state_nxt;
  logic [IDX_W-1:0] rd_idx_p0;
  logic [IDX_W-1:0] idx_p1;
  logic             vld_p1;
  logic             relu_mode;
  logic             start_acc;
  logic             idle;
  logic             wm_addr_ok;
  logic [DATA_WIDTH-1:0] elem_p1;

  assign idle       = (state == IDLE);
  assign wm_addr_ok = (32'(riscv_address) < 32'(IFM_DEPTH));

  always_comb begin
    state_nxt       = state;
    busy            = 1'b1;
    end_to_previous = 1'b0;
    start_acc       = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start_from_previous) begin
          start_acc = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (rd_idx_p0 == IDX_W'(IFM_DEPTH - 1))
          state_nxt = DRAIN;
      end
      DRAIN:  state_nxt = FINISH;
      FINISH: begin
        end_to_previous = 1'b1;
        state_nxt       = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      rd_idx_p0    <= '0;
      vld_p1       <= 1'b0;
      output_valid <= 1'b0;
      output_ready <= 1'b0;
      relu_mode    <= RELU_EN;
    end else begin
      state        <= state_nxt;
      vld_p1       <= (state == RUN);
      output_valid <= (state == FINISH);
      if (start_acc)
        output_ready <= 1'b0;
      else if (state == FINISH)
        output_ready <= 1'b1;
      if (state == RUN)
        rd_idx_p0 <= rd_idx_p0 + 1'b1;
      else
        rd_idx_p0 <= '0;
      if (idle && relu_mode_wr)
        relu_mode <= riscv_data[0];
    end
  end

  // p0 -> p1: element index follows the weight read by one cycle
  always_ff @(posedge clk) begin
    idx_p1 <= rd_idx_p0;
  end

  assign elem_p1 = ifm_data[int'(idx_p1)*DATA_WIDTH +: DATA_WIDTH];

  for (genvar n = 0; n < NUM_NEURONS; n++) begin : g_lane
    logic wm_we_n;
    logic bm_we_n;

    assign wm_we_n = idle && wm_addr_ok && wm_enable_write[n];
    assign bm_we_n = idle && bm_enable_write && (32'(riscv_address) == 32'(n));

    fc_mac_lane #(
      .DATA_W    (DATA_WIDTH),
      .FRAC_BITS (FRAC_BITS),
      .DEPTH     (IFM_DEPTH),
      .IDX_W     (IDX_W)
    ) u_lane (
      .clk        (clk),
      .rst        (reset),
      .wm_we      (wm_we_n),
      .wm_addr    (riscv_address[IDX_W-1:0]),
      .wr_data    (riscv_data),
      .bm_we      (bm_we_n),
      .rd_addr_p0 (rd_idx_p0),
      .elem_p1    (elem_p1),
      .vld_p1     (vld_p1),
      .acc_clr    (start_acc),
      .fin_en     (state == FINISH),
      .relu_mode  (relu_mode),
      .result     (fc_out[n*DATA_WIDTH +: DATA_WIDTH])
    );
  end

endmodule

// File: tb/tb_fc_layer_gen.sv
// Randomised self-checking bench for fc_layer_gen against a plain-arithmetic dot-product model.
module tb_fc_layer_gen;

  localparam int DW = 16;
  localparam int FB = 8;
  localparam int D  = 4;
  localparam int N  = 2;
  localparam int AB = 15;

  logic            clk = 1'b0;
  logic            reset;
  logic [DW-1:0]   riscv_data;
  logic [AB-1:0]   riscv_address;
  logic [N-1:0]    wm_enable_write;
  logic            bm_enable_write;
  logic            relu_mode_wr;
  logic            start_from_previous;
  logic [D*DW-1:0] ifm_data;
  logic            end_to_previous;
  logic [N*DW-1:0] fc_out;
  logic            output_valid;
  logic            output_ready;
  logic            busy;

  fc_layer_gen #(
    .DATA_WIDTH   (DW),
    .FRAC_BITS    (FB),
    .IFM_DEPTH    (D),
    .NUM_NEURONS  (N),
    .ADDRESS_BITS (AB),
    .RELU_EN      (1'b0)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .riscv_data          (riscv_data),
    .riscv_address       (riscv_address),
    .wm_enable_write     (wm_enable_write),
    .bm_enable_write     (bm_enable_write),
    .relu_mode_wr        (relu_mode_wr),
    .start_from_previous (start_from_previous),
    .ifm_data            (ifm_data),
    .end_to_previous     (end_to_previous),
    .fc_out              (fc_out),
    .output_valid        (output_valid),
    .output_ready        (output_ready),
    .busy                (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: what the host believes is loaded
  int m_w [N][D];
  int m_b [N];
  bit m_relu;
  int m_x [D];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int sx(input logic [DW-1:0] v);
    return int'($signed(v));
  endfunction

  // Dot product in Q(FB) with floor-shifted products, 2*DW wrapping sum, clamp, optional ReLU.
  function automatic int model_neuron(input int n);
    int     acc;
    longint p;
    longint s;
    acc = 0;
    for (int k = 0; k < D; k++) begin
      p   = longint'(m_w[n][k]) * longint'(m_x[k]);
      p   = p >>> FB;
      acc = acc + int'(p);
    end
    s = longint'(acc) + longint'(m_b[n]);
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
    if (m_relu && s < 0) s = 0;
    return int'(s);
  endfunction

  task automatic wr_w(input logic [N-1:0] mask, input int addr, input int data);
    riscv_data      = DW'(data);
    riscv_address   = AB'(addr);
    wm_enable_write = mask;
    @(negedge clk);
    wm_enable_write = '0;
    if (addr < D)
      for (int n = 0; n < N; n++)
        if (mask[n]) m_w[n][addr] = sx(DW'(data));
  endtask

  task automatic wr_b(input int addr, input int data);
    riscv_data      = DW'(data);
    riscv_address   = AB'(addr);
    bm_enable_write = 1'b1;
    @(negedge clk);
    bm_enable_write = 1'b0;
    if (addr < N) m_b[addr] = sx(DW'(data));
  endtask

  task automatic wr_relu(input bit v);
    riscv_data   = DW'(v);
    relu_mode_wr = 1'b1;
    @(negedge clk);
    relu_mode_wr = 1'b0;
    m_relu = v;
  endtask

  task automatic set_x(input int k, input int v);
    ifm_data[k*DW +: DW] = DW'(v);
    m_x[k] = sx(DW'(v));
  endtask

  // Start in the current cycle (j=0) and observe 16 following cycles.
  task automatic run_check(input string tag, input int restart_j, input int busy_wr_j);
    int etp_j, val_j, val2_j, nval, exp_n;
    logic busy_j1;
    etp_j = 0; val_j = 0; val2_j = 0; nval = 0; busy_j1 = 1'b0;
    exp_n = (restart_j >= D + 3) ? 2 : 1;
    start_from_previous = 1'b1;
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      if (j == 1) busy_j1 = busy;
      start_from_previous = (j == restart_j);
      if (j == busy_wr_j) begin
        riscv_address   = '0;
        riscv_data      = 16'h1235;
        wm_enable_write = '1;
        bm_enable_write = 1'b1;
        relu_mode_wr    = 1'b1;
      end else begin
        wm_enable_write = '0;
        bm_enable_write = 1'b0;
        relu_mode_wr    = 1'b0;
      end
      if (end_to_previous && etp_j == 0) etp_j = j;
      if (output_valid) begin
        nval++;
        if (val_j == 0) val_j = j;
        else if (val2_j == 0) val2_j = j;
      end
    end
    check_val({tag, "_busy"}, 32'(busy_j1), 32'd1);
    check_val({tag, "_etp_cycle"}, 32'(etp_j), 32'(D + 2));
    check_val({tag, "_valid_cycle"}, 32'(val_j), 32'(D + 3));
    check_val({tag, "_valid_count"}, 32'(nval), 32'(exp_n));
    if (exp_n == 2)
      check_val({tag, "_valid2_cycle"}, 32'(val2_j), 32'(2 * (D + 3)));
    check_val({tag, "_ready"}, 32'(output_ready), 32'd1);
    check_val({tag, "_idle"}, 32'(busy), 32'd0);
    for (int n = 0; n < N; n++)
      check_val($sformatf("%s_out%0d", tag, n), 32'(fc_out[n*DW +: DW]),
                32'(model_neuron(n)) & 32'hFFFF);
  endtask

  task automatic check_lane(input string tag, input int n, input logic [DW-1:0] exp);
    check_val(tag, 32'(fc_out[n*DW +: DW]), 32'(exp));
  endtask

  initial begin
    reset = 1'b1;
    riscv_data = '0; riscv_address = '0; wm_enable_write = '0;
    bm_enable_write = 1'b0; relu_mode_wr = 1'b0; start_from_previous = 1'b0;
    ifm_data = '0;
    for (int k = 0; k < D; k++) m_x[k] = 0;
    for (int n = 0; n < N; n++) m_b[n] = 0;
    m_relu = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_fc_out", 32'(fc_out), 32'd0);
    check_val("rst_valid", 32'(output_valid), 32'd0);
    check_val("rst_ready", 32'(output_ready), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_etp", 32'(end_to_previous), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Scenario 1: basic Q8.8 dot products
    for (int k = 0; k < D; k++) begin
      set_x(k, 16'h0100);
      wr_w(2'b01, k, 16'h0080);
      wr_w(2'b10, k, 16'h0100);
    end
    wr_b(0, 0);
    wr_b(1, 16'h0100);
    run_check("s1", 0, 0);
    check_lane("s1_const0", 0, 16'h0200);
    check_lane("s1_const1", 1, 16'h0500);

    // Scenario 3: start mid-run ignored, start on the idle cycle accepted
    run_check("s3_ignored", 3, 0);
    run_check("s3_b2b", D + 3, 0);

    // Scenario 4: reset during RUN
    start_from_previous = 1'b1;
    for (int j = 1; j <= 3; j++) begin
      @(negedge clk);
      start_from_previous = 1'b0;
      if (j == 3) reset = 1'b1;
    end
    @(negedge clk);
    check_val("s4_busy", 32'(busy), 32'd0);
    check_val("s4_fc_out", 32'(fc_out), 32'd0);
    check_val("s4_ready", 32'(output_ready), 32'd0);
    reset = 1'b0;
    for (int n = 0; n < N; n++) m_b[n] = 0;
    m_relu = 1'b0;
    @(negedge clk);
    wr_b(1, 16'h0100);
    run_check("s4_rerun", 0, 0);
    check_lane("s4_const0", 0, 16'h0200);
    check_lane("s4_const1", 1, 16'h0500);

    // Scenario 2: saturation both ways and ReLU
    wr_b(0, 0);
    wr_b(1, 0);
    for (int k = 0; k < D; k++) begin
      set_x(k, 16'h7FFF);
      wr_w(2'b11, k, 16'h7FFF);
    end
    run_check("s2_pos", 0, 0);
    check_lane("s2_pos_const", 0, 16'h7FFF);
    for (int k = 0; k < D; k++) wr_w(2'b11, k, 16'h8001);
    run_check("s2_neg", 0, 0);
    check_lane("s2_neg_const", 1, 16'h8000);
    wr_relu(1'b1);
    run_check("s2_relu", 0, 0);
    check_lane("s2_relu_const", 0, 16'h0000);
    wr_relu(1'b0);

    // Scenario 6: bias exactly cancelling a negative sum
    for (int k = 0; k < D; k++) begin
      set_x(k, (k + 1) * 16'h0100);
      wr_w(2'b11, k, 16'hFF00);
    end
    wr_b(0, 16'h0A00);
    wr_b(1, 16'h0900);
    run_check("s6", 0, 0);
    check_lane("s6_const0", 0, 16'h0000);
    check_lane("s6_const1", 1, 16'hFF00);

    // Scenario 5: host writes while busy, out-of-range addresses, broadcast write
    run_check("s5_busywr", 0, 2);
    run_check("s5_after", 0, 0);
    wr_w(2'b11, D, 16'h4000);
    wr_b(N, 16'h3000);
    run_check("s5_oob", 0, 0);
    for (int k = 0; k < D; k++) wr_w(2'b11, k, $urandom_range(0, 16'hFFFF));
    wr_b(0, 16'h0040);
    wr_b(1, 16'h0040);
    run_check("s5_bcast", 0, 0);

    // Randomised vectors, weights, biases and ReLU mode
    for (int it = 0; it < 10; it++) begin
      for (int k = 0; k < D; k++) begin
        set_x(k, (it < 5) ? $urandom_range(0, 16'hFFFF) : $urandom_range(0, 16'h03FF) - 16'h0200);
        for (int n = 0; n < N; n++)
          wr_w(N'(1 << n), k, (it < 5) ? $urandom_range(0, 16'hFFFF)
                                       : $urandom_range(0, 16'h03FF) - 16'h0200);
      end
      for (int n = 0; n < N; n++) wr_b(n, $urandom_range(0, 16'hFFFF));
      wr_relu(1'($urandom_range(0, 1)));
      run_check($sformatf("rnd%0d", it), 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
